softmax_seq_ctrl: RTL

SOFTMAX_SEQ_CTRL -- requirements
Module: softmax_seq_ctrl

---
 rtl/softmax_seq_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - softmax vector sequencer: loads elements through a shared exp unit,
// buffers linear exps with a saturating sum, then replays them with the vector total.
module softmax_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int X_W   = 17,
    parameter int E_W   = 21
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_x,
    input  logic           in_last,
    output logic [X_W-1:0] exp_x,
    input  logic [E_W-1:0] exp_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_e,
    output logic [35:0]    out_sum,
    output logic           out_last,
    output logic           busy,
    output logic           sat,
    output logic           trunc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUT} state_t;

    state_t         state_q;
    logic [X_W-1:0] exp_x_q;
    logic           pend_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  idx_q;
    logic [35:0]    sum_q;
    logic           sat_q;
    logic           trunc_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [31:0]    out_e_q;
    logic [35:0]    out_sum_q;
    logic           out_last_q;
    logic [31:0]    buffer [DEPTH];

    logic [4:0]     pos;
    logic [15:0]    mant;
    logic           conv_sat;
    logic [4:0]     shamt;
    logic [31:0]    lin;
    logic [36:0]    sum_add;
    logic [35:0]    sum_d;
    logic           sat_d;
    logic           accept;
    logic [CW-1:0]  acc_cnt;
    logic           hit_depth;
    logic [CW-1:0]  idx_d;

    // exp_y always reflects exp_x_q, i.e. the element accepted on the previous edge
    always_comb begin
        pos       = exp_y[20:16];
        mant      = exp_y[15:0];
        conv_sat  = (pos > 5'd16);
        shamt     = conv_sat ? 5'd16 : pos;
        lin       = {16'd0, mant} << shamt;
        sum_add   = {1'b0, sum_q} + {5'd0, lin};
        sum_d     = sum_add[36] ? 36'hF_FFFF_FFFF : sum_add[35:0];
        sat_d     = sat_q | conv_sat | sum_add[36];
        accept    = in_valid && in_ready_q;
        acc_cnt   = count_q + CW'(pend_q);
        hit_depth = (acc_cnt == CW'(DEPTH - 1));
        idx_d     = idx_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (pend_q) begin
            buffer[count_q[AW-1:0]] <= lin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            exp_x_q     <= '0;
            pend_q      <= 1'b0;
            count_q     <= '0;
            idx_q       <= '0;
            sum_q       <= '0;
            sat_q       <= 1'b0;
            trunc_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_e_q     <= '0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                exp_x_q <= in_x;
            end
            pend_q <= accept;
            if (pend_q) begin
                count_q <= count_q + CW'(1);
                sum_q   <= sum_d;
                sat_q   <= sat_d;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        count_q    <= '0;
                        sum_q      <= '0;
                        sat_q      <= 1'b0;
                        trunc_q    <= 1'b0;
                        in_ready_q <= !in_last;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept && (in_last || hit_depth)) begin
                        trunc_q    <= !in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= S_DRAIN;
                    end else if (!in_ready_q) begin
                        // single-element vector: its terminator was taken in IDLE
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    idx_q       <= '0;
                    out_valid_q <= 1'b1;
                    out_sum_q   <= pend_q ? sum_d : sum_q;
                    out_e_q     <= (pend_q && count_q == '0) ? lin : buffer[0];
                    out_last_q  <= (acc_cnt == CW'(1));
                    state_q     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            idx_q      <= idx_d;
                            out_e_q    <= buffer[idx_d[AW-1:0]];
                            out_last_q <= ((idx_q + CW'(2)) == count_q);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign exp_x     = exp_x_q;
    assign out_valid = out_valid_q;
    assign out_e     = out_e_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign sat       = sat_q;
    assign trunc     = trunc_q;

endmodule
